// File: rtl/lc4_commit_checker_pkg.sv
// Shared definitions for the LC4 commit checker: trace record layout, stall codes,
// state and error-field encodings, and the per-lane record comparator.
package lc4_commit_checker_pkg;

    localparam int unsigned RecW = 89;

    // Field order matches {pc,insn,rf_we,rf_reg,rf_data,nzp_we,nzp,dm_we,dm_addr,dm_data}
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] insn;
        logic        rf_we;
        logic [2:0]  rf_reg;
        logic [15:0] rf_data;
        logic        nzp_we;
        logic [2:0]  nzp;
        logic        dm_we;
        logic [15:0] dm_addr;
        logic [15:0] dm_data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDone  = 2'd2,
        StError = 2'd3
    } state_e;

    localparam logic [1:0] StallNone   = 2'd0;
    localparam logic [1:0] StallCache  = 2'd1;
    localparam logic [1:0] StallBranch = 2'd2;
    localparam logic [1:0] StallLoad   = 2'd3;

    localparam logic [3:0] FieldNone     = 4'd0;
    localparam logic [3:0] FieldPc       = 4'd1;
    localparam logic [3:0] FieldInsn     = 4'd2;
    localparam logic [3:0] FieldRfWe     = 4'd3;
    localparam logic [3:0] FieldRfReg    = 4'd4;
    localparam logic [3:0] FieldRfData   = 4'd5;
    localparam logic [3:0] FieldNzpWe    = 4'd6;
    localparam logic [3:0] FieldNzp      = 4'd7;
    localparam logic [3:0] FieldDmWe     = 4'd8;
    localparam logic [3:0] FieldDmAddr   = 4'd9;
    localparam logic [3:0] FieldDmData   = 4'd10;
    localparam logic [3:0] FieldUnderrun = 4'd11;
    localparam logic [3:0] FieldOrder    = 4'd12;

    typedef struct packed {
        logic [3:0]  field;
        logic [15:0] exp_val;
        logic [15:0] act_val;
    } cmp_res_t;

    // Lowest failing field code wins; !== so that X/Z actuals flag a mismatch in simulation.
    function automatic cmp_res_t compare_rec(input trace_rec_t e, input trace_rec_t a);
        cmp_res_t r;
        r = '0;
        if (a.pc !== e.pc) begin
            r = '{FieldPc, e.pc, a.pc};
        end else if (a.insn !== e.insn) begin
            r = '{FieldInsn, e.insn, a.insn};
        end else if (a.rf_we !== e.rf_we) begin
            r = '{FieldRfWe, 16'(e.rf_we), 16'(a.rf_we)};
        end else if (e.rf_we && (a.rf_reg !== e.rf_reg)) begin
            r = '{FieldRfReg, 16'(e.rf_reg), 16'(a.rf_reg)};
        end else if (e.rf_we && (a.rf_data !== e.rf_data)) begin
            r = '{FieldRfData, e.rf_data, a.rf_data};
        end else if (a.nzp_we !== e.nzp_we) begin
            r = '{FieldNzpWe, 16'(e.nzp_we), 16'(a.nzp_we)};
        end else if (e.nzp_we && (a.nzp !== e.nzp)) begin
            r = '{FieldNzp, 16'(e.nzp), 16'(a.nzp)};
        end else if (a.dm_we !== e.dm_we) begin
            r = '{FieldDmWe, 16'(e.dm_we), 16'(a.dm_we)};
        end else if (a.dm_addr !== e.dm_addr) begin
            r = '{FieldDmAddr, e.dm_addr, a.dm_addr};
        end else if (a.dm_data !== e.dm_data) begin
            r = '{FieldDmData, e.dm_data, a.dm_data};
        end
        return r;
    endfunction

endpackage

// File: rtl/lc4_commit_checker_fifo.sv
// Expected-record FIFO: one push and 0..LANES pops per cycle, with the LANES oldest
// entries visible combinationally. Entry MSB carries the trace-last flag.
module lc4_commit_checker_fifo
    import lc4_commit_checker_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic [RecW:0]            push_data,
    input  logic [2:0]               pop_n,
    output logic [LANES-1:0][RecW:0] head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [RecW:0]   mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_q + AW'(pop_n);
            count_q  <= count_q + CW'(push) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            head[i] = mem[rd_ptr_q + AW'(i)];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lc4_commit_checker.sv
// In-order commit checker and stall-cause performance counters for an N-wide LC4 pipeline.
// Compares each committing lane against buffered expected records; captures the first error.
module lc4_commit_checker
    import lc4_commit_checker_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CNT_W       = 32,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gwe,
    input  logic                  start,
    input  logic                  soft_clr,
    input  logic [2*LANES-1:0]    test_stall,
    input  logic [16*LANES-1:0]   test_pc,
    input  logic [16*LANES-1:0]   test_insn,
    input  logic [16*LANES-1:0]   test_regfile_data,
    input  logic [16*LANES-1:0]   test_dmem_addr,
    input  logic [16*LANES-1:0]   test_dmem_data,
    input  logic [LANES-1:0]      test_regfile_we,
    input  logic [LANES-1:0]      test_nzp_we,
    input  logic [LANES-1:0]      test_dmem_we,
    input  logic [3*LANES-1:0]    test_regfile_wsel,
    input  logic [3*LANES-1:0]    test_nzp_new_bits,
    input  logic                  exp_valid,
    output logic                  exp_ready,
    input  logic [RecW-1:0]       exp_rec,
    input  logic                  exp_last,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      cyc_cnt,
    output logic [CNT_W-1:0]      insn_cnt,
    output logic [CNT_W-1:0]      cache_cnt,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      load_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      err_index,
    output logic [3:0]            err_field,
    output logic [1:0]            err_lane,
    output logic [15:0]           err_exp,
    output logic [15:0]           err_act
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, insn_q, insn_d, cache_q, cache_d;
    logic [CNT_W-1:0] branch_q, branch_d, load_q, load_d, errc_q, errc_d;
    logic [CNT_W-1:0] eidx_q, eidx_d;
    logic [3:0]       efld_q, efld_d;
    logic [1:0]       elane_q, elane_d;
    logic [15:0]      eexp_q, eexp_d, eact_q, eact_d;

    logic                     clr;
    logic                     push;
    logic [2:0]               pop_n;
    logic [LANES-1:0][RecW:0] head;
    logic [CW-1:0]            fifo_count;

    trace_rec_t act_rec [LANES];
    trace_rec_t exp_r;
    cmp_res_t   lane_res;
    logic [2:0] n_commit, n_cache, n_branch, n_load;
    logic       seen_stall, ord_err;
    logic [1:0] ord_lane;
    logic       hit, past_last;
    logic [1:0] hit_lane;
    cmp_res_t   hit_res;
    logic       mis;
    logic [1:0] mis_lane;
    cmp_res_t   mis_res;

    assign clr       = rst | soft_clr;
    assign exp_ready = fifo_count < CW'(DEPTH);
    assign push      = gwe && exp_valid && exp_ready && (state_q != StError);

    lc4_commit_checker_fifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_data ({exp_last, exp_rec}),
        .pop_n     (pop_n),
        .head      (head),
        .count     (fifo_count)
    );

    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            act_rec[i] = '{pc:      test_pc[16*i +: 16],
                           insn:    test_insn[16*i +: 16],
                           rf_we:   test_regfile_we[i],
                           rf_reg:  test_regfile_wsel[3*i +: 3],
                           rf_data: test_regfile_data[16*i +: 16],
                           nzp_we:  test_nzp_we[i],
                           nzp:     test_nzp_new_bits[3*i +: 3],
                           dm_we:   test_dmem_we[i],
                           dm_addr: test_dmem_addr[16*i +: 16],
                           dm_data: test_dmem_data[16*i +: 16]};
        end
    end

    // Stall-cause tally and commit-prefix (ordering) check.
    always_comb begin
        n_commit   = '0;
        n_cache    = '0;
        n_branch   = '0;
        n_load     = '0;
        seen_stall = 1'b0;
        ord_err    = 1'b0;
        ord_lane   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            case (test_stall[2*i +: 2])
                StallNone:   n_commit = n_commit + 3'd1;
                StallCache:  n_cache  = n_cache + 3'd1;
                StallBranch: n_branch = n_branch + 3'd1;
                default:     n_load   = n_load + 3'd1;
            endcase
            if (test_stall[2*i +: 2] != StallNone) begin
                seen_stall = 1'b1;
            end else if (seen_stall && !ord_err) begin
                ord_err  = 1'b1;
                ord_lane = 2'(i);
            end
        end
    end

    // Per-lane comparison; any lane committing after a trace-last record is an underrun.
    always_comb begin
        hit       = 1'b0;
        hit_lane  = '0;
        hit_res   = '0;
        past_last = 1'b0;
        exp_r     = '0;
        lane_res  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (i < int'(n_commit)) begin
                exp_r = trace_rec_t'(head[i][RecW-1:0]);
                if (past_last) begin
                    lane_res = '{FieldUnderrun, 16'h0000, 16'h0000};
                end else begin
                    lane_res = compare_rec(exp_r, act_rec[i]);
                end
                if (!hit && (lane_res.field != FieldNone)) begin
                    hit      = 1'b1;
                    hit_lane = 2'(i);
                    hit_res  = lane_res;
                end
                if (head[i][RecW]) begin
                    past_last = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        insn_d   = insn_q;
        cache_d  = cache_q;
        branch_d = branch_q;
        load_d   = load_q;
        errc_d   = errc_q;
        eidx_d   = eidx_q;
        efld_d   = efld_q;
        elane_d  = elane_q;
        eexp_d   = eexp_q;
        eact_d   = eact_q;
        pop_n    = '0;
        mis      = 1'b0;
        mis_lane = '0;
        mis_res  = '0;
        if (gwe) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    cyc_d    = sat_add(cyc_q, 3'd1);
                    cache_d  = sat_add(cache_q, n_cache);
                    branch_d = sat_add(branch_q, n_branch);
                    load_d   = sat_add(load_q, n_load);
                    if (ord_err) begin
                        mis      = 1'b1;
                        mis_lane = ord_lane;
                        mis_res  = '{FieldOrder, 16'h0000, 16'h0000};
                    end else if (int'(n_commit) > int'(fifo_count)) begin
                        mis      = 1'b1;
                        mis_lane = 2'(fifo_count);
                        mis_res  = '{FieldUnderrun, 16'h0000, 16'h0000};
                    end else begin
                        pop_n  = n_commit;
                        insn_d = sat_add(insn_q, n_commit);
                        if (hit) begin
                            mis      = 1'b1;
                            mis_lane = hit_lane;
                            mis_res  = hit_res;
                        end else if (past_last) begin
                            state_d = StDone;
                        end
                    end
                    if (mis) begin
                        errc_d = sat_add(errc_q, 3'd1);
                        if (efld_q == FieldNone) begin
                            efld_d  = mis_res.field;
                            elane_d = mis_lane;
                            eexp_d  = mis_res.exp_val;
                            eact_d  = mis_res.act_val;
                            eidx_d  = sat_add(insn_q, {1'b0, mis_lane});
                        end
                        if (STOP_ON_ERR) begin
                            state_d = StError;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            insn_q   <= '0;
            cache_q  <= '0;
            branch_q <= '0;
            load_q   <= '0;
            errc_q   <= '0;
            eidx_q   <= '0;
            efld_q   <= FieldNone;
            elane_q  <= '0;
            eexp_q   <= '0;
            eact_q   <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            insn_q   <= insn_d;
            cache_q  <= cache_d;
            branch_q <= branch_d;
            load_q   <= load_d;
            errc_q   <= errc_d;
            eidx_q   <= eidx_d;
            efld_q   <= efld_d;
            elane_q  <= elane_d;
            eexp_q   <= eexp_d;
            eact_q   <= eact_d;
        end
    end

    assign state      = state_q;
    assign cyc_cnt    = cyc_q;
    assign insn_cnt   = insn_q;
    assign cache_cnt  = cache_q;
    assign branch_cnt = branch_q;
    assign load_cnt   = load_q;
    assign err_cnt    = errc_q;
    assign err_index  = eidx_q;
    assign err_field  = efld_q;
    assign err_lane   = elane_q;
    assign err_exp    = eexp_q;
    assign err_act    = eact_q;

endmodule
